lcd_refresh_ctrl: RTL and testbench

- Sequencer that owns the character LCD (HD44780-style, 8-bit bus, 2x16).
- Runs the power-up init, then on request walks index 0..31 through the active mode block (stopwatch, clock, alarm) and writes each returned ASCII byte to the LCD.
- Issues line-address commands at index 0 and 16, and generates all E/RS timing.
- Sits between the mode-select mux (char_in) and the LCD pins.

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_write_timer.sv | 73 +++++++
 rtl/lcd_refresh_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_lcd_refresh_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - states, LCD command bytes and sizing helpers for the refresh controller
package lcd_pkg;

  typedef enum logic [3:0] {
    PWRUP, INIT_SETUP, INIT_E, INIT_WAIT, IDLE,
    ADDR_SETUP, ADDR_E, ADDR_WAIT, FETCH,
    DATA_SETUP, DATA_E, DATA_WAIT
  } lcd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE, WR_E, WR_WAIT
  } wr_phase_e;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  localparam int LCD_CHARS = 32;
  localparam logic [4:0] LAST_IDX   = 5'(LCD_CHARS - 1);
  localparam logic [4:0] LINE1_LAST = 5'(LCD_CHARS / 2 - 1);
  localparam logic [4:0] LINE2_IDX  = 5'(LCD_CHARS / 2);

  // Power-up command sequence, one byte per init step.
  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_CLEAR;
      default: return LCD_ENTRY;
    endcase
  endfunction

  // Counter width able to hold the largest of the wait parameters.
  function automatic int cnt_width(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lcd_write_timer.sv
// rtl/lcd_write_timer.sv - E-strobe and post-write wait sequencer shared by command and data writes
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle request issued from a SETUP state
//   is_clear     selects the long post-write wait (clear command)
//   lcd_e        enable strobe, high for E_PULSE_CYC clocks
//   done         high in the last wait cycle; the caller leaves its WAIT state on it
module lcd_write_timer
  import lcd_pkg::*;
#(
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2_500,
  parameter int CLR_WAIT_CYC = 100_000,
  parameter int CW           = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_clear,
  output logic lcd_e,
  output logic done
);

  wr_phase_e       phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            clr_q, clr_d;
  logic [CW-1:0]   wait_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= WR_IDLE;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    clr_d     = clr_q;
    done      = 1'b0;
    wait_last = clr_q ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
    case (phase_q)
      WR_IDLE: if (start) begin
        phase_d = WR_E;
        cnt_d   = '0;
        clr_d   = is_clear;
      end
      WR_E: if (cnt_q == CW'(E_PULSE_CYC - 1)) begin
        phase_d = WR_WAIT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      WR_WAIT: if (cnt_q == wait_last) begin
        done    = 1'b1;
        phase_d = WR_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: phase_d = WR_IDLE;
    endcase
  end

  // Decoded straight from the phase flop so reset removes the strobe at once.
  assign lcd_e = (phase_q == WR_E);

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// rtl/lcd_refresh_ctrl.sv - HD44780 power-up init and 2x16 frame refresh sequencer
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   refresh      frame request pulse
//   char_in      ASCII byte for the current index (registered by the mode block)
//   index        character position 0..31 being requested
//   lcd_rs/rw/e  LCD control pins (rw tied low)
//   lcd_data     LCD data bus
//   init_done    init sequence complete
//   busy         frame in progress
//   frame_done   one-cycle pulse after the last character's wait
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC    = 2_000_000,
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2_500,
  parameter int CLR_WAIT_CYC = 100_000,
  parameter int FETCH_CYC    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refresh,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = cnt_width(PWRUP_CYC, E_PULSE_CYC, CMD_WAIT_CYC, CLR_WAIT_CYC, FETCH_CYC);

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    step_q, step_d;
  logic [4:0]    index_q, index_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          init_done_q, init_done_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          pending_q, pending_d;

  logic wr_start, wr_is_clear, wr_e, wr_done;
  logic pwrup_last, fetch_last, go;

  assign wr_start    = (state_q == INIT_SETUP) || (state_q == ADDR_SETUP) || (state_q == DATA_SETUP);
  assign wr_is_clear = (state_q == INIT_SETUP) && (init_cmd(step_q) == LCD_CLEAR);
  assign pwrup_last  = (cnt_q == CW'(PWRUP_CYC - 1));
  assign fetch_last  = (cnt_q == CW'(FETCH_CYC - 1));
  assign go          = (state_q == IDLE) && (refresh || pending_q);

  lcd_write_timer #(
    .E_PULSE_CYC  (E_PULSE_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC),
    .CW           (CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .start    (wr_start),
    .is_clear (wr_is_clear),
    .lcd_e    (wr_e),
    .done     (wr_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PWRUP;
      cnt_q        <= '0;
      step_q       <= 2'd0;
      index_q      <= 5'd0;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      index_q      <= index_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      pending_q    <= pending_d;
    end
  end

  // E and WAIT states are handled together: the state label trails the
  // timer's strobe by a cycle, and done may arrive while still labelled E.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PWRUP:      if (pwrup_last) state_d = INIT_SETUP;
      INIT_SETUP: state_d = INIT_E;
      INIT_E, INIT_WAIT: begin
        if (wr_done)    state_d = (step_q == 2'd3) ? IDLE : INIT_SETUP;
        else if (!wr_e) state_d = INIT_WAIT;
      end
      IDLE:       if (go) state_d = ADDR_SETUP;
      ADDR_SETUP: state_d = ADDR_E;
      ADDR_E, ADDR_WAIT: begin
        if (wr_done)    state_d = FETCH;
        else if (!wr_e) state_d = ADDR_WAIT;
      end
      FETCH:      if (fetch_last) state_d = DATA_SETUP;
      DATA_SETUP: state_d = DATA_E;
      DATA_E, DATA_WAIT: begin
        if (wr_done) begin
          if (index_q == LAST_IDX)        state_d = IDLE;
          else if (index_q == LINE1_LAST) state_d = ADDR_SETUP;
          else                            state_d = FETCH;
        end else if (!wr_e) begin
          state_d = DATA_WAIT;
        end
      end
      default:    state_d = PWRUP;
    endcase
  end

  // Bus values are loaded on the edge that enters a SETUP state, so they
  // are settled before the strobe and held until the next write.
  always_comb begin
    cnt_d        = cnt_q;
    step_d       = step_q;
    index_d      = index_q;
    rs_d         = rs_q;
    data_d       = data_q;
    init_done_d  = init_done_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    pending_d    = pending_q;
    if (refresh && (busy_q || !init_done_q)) pending_d = 1'b1;
    case (state_q)
      PWRUP: begin
        if (pwrup_last) begin
          cnt_d  = '0;
          step_d = 2'd0;
          rs_d   = 1'b0;
          data_d = init_cmd(2'd0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      INIT_E, INIT_WAIT: begin
        if (wr_done) begin
          if (step_q == 2'd3) begin
            init_done_d = 1'b1;
          end else begin
            step_d = step_q + 2'd1;
            data_d = init_cmd(step_q + 2'd1);
          end
        end
      end
      IDLE: begin
        if (go) begin
          pending_d = 1'b0;
          index_d   = 5'd0;
          busy_d    = 1'b1;
          rs_d      = 1'b0;
          data_d    = LCD_LINE1;
        end
      end
      FETCH: begin
        if (fetch_last) begin
          cnt_d  = '0;
          rs_d   = 1'b1;
          data_d = char_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA_E, DATA_WAIT: begin
        if (wr_done) begin
          if (index_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            index_d      = 5'd0;
          end else if (index_q == LINE1_LAST) begin
            index_d = LINE2_IDX;
            rs_d    = 1'b0;
            data_d  = LCD_LINE2;
          end else begin
            index_d = index_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign index      = index_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_e      = wr_e;
  assign lcd_data   = data_q;
  assign init_done  = init_done_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// tb/tb_lcd_refresh_ctrl.sv - self-checking bench for lcd_refresh_ctrl
module tb_lcd_refresh_ctrl;

  localparam int PWRUP = 10;
  localparam int EP    = 2;
  localparam int CMDW  = 3;
  localparam int CLRW  = 8;
  localparam int FET   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       refresh = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic [4:0] index;
  logic       lcd_rs, lcd_rw, lcd_e, init_done, busy, frame_done;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_refresh_ctrl #(
    .PWRUP_CYC    (PWRUP),
    .E_PULSE_CYC  (EP),
    .CMD_WAIT_CYC (CMDW),
    .CLR_WAIT_CYC (CLRW),
    .FETCH_CYC    (FET)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .refresh    (refresh),
    .char_in    (char_in),
    .index      (index),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .lcd_data   (lcd_data),
    .init_done  (init_done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Mode block: one-cycle registered lookup of the current index.
  logic [7:0] tbl [32];
  always @(posedge clk) char_in <= tbl[index];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  // Bus monitor: logs every write {rs,data} at the strobe's rising edge.
  logic [8:0] writes [$];
  int         rises [$];
  int         falls [$];
  int         fd_count = 0;
  logic       prev_e = 1'b0, prev_fd = 1'b0;
  logic [8:0] prev_rsd = 9'd0;

  always @(negedge clk) begin
    checks++;
    if (lcd_rw !== 1'b0) begin
      errors++;
      $display("FAIL rw_tied lcd_rw=%b required 0", lcd_rw);
    end
    if (lcd_e && prev_e) begin
      checks++;
      if ({lcd_rs, lcd_data} !== prev_rsd) begin
        errors++;
        $display("FAIL bus_stable_during_e got %h required %h", {lcd_rs, lcd_data}, prev_rsd);
      end
    end
    if (lcd_e && !prev_e) begin
      writes.push_back({lcd_rs, lcd_data});
      rises.push_back(cyc);
    end
    if (!lcd_e && prev_e) falls.push_back(cyc);
    if (frame_done) begin
      fd_count++;
      checks++;
      if (prev_fd) begin
        errors++;
        $display("FAIL frame_done_width pulse longer than 1 clk");
      end
    end
    prev_e   <= lcd_e;
    prev_rsd <= {lcd_rs, lcd_data};
    prev_fd  <= frame_done;
  end

  task automatic pulse_refresh();
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({index, lcd_rs, lcd_e, lcd_data} !== 15'd0) begin
      errors++;
      $display("FAIL reset_bus got idx=%0d rs=%b e=%b data=%h required 0", index, lcd_rs, lcd_e, lcd_data);
    end
    checks++;
    if ({init_done, busy, frame_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b required 000", {init_done, busy, frame_done});
    end
  endtask

  // Releases reset and checks the whole power-up command sequence.
  task automatic test_init();
    int rel, rb, wb, fb, w;
    rb = rises.size();
    wb = writes.size();
    fb = falls.size();
    @(negedge clk);
    rst = 1'b1;
    rel = cyc;
    for (int k = 0; k < 400 && !init_done; k++) @(negedge clk);
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_timeout init_done=%b required 1", init_done);
    end
    checks++;
    if (writes.size() - wb != 4 || falls.size() - fb != 4) begin
      errors++;
      $display("FAIL init_count got %0d writes required 4", writes.size() - wb);
    end else begin
      checks++;
      if (rises[rb] - rel != PWRUP + 1) begin
        errors++;
        $display("FAIL init_first_e got %0d clks required %0d", rises[rb] - rel, PWRUP + 1);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (writes[wb + i] !== {1'b0, init_cmds[i]}) begin
          errors++;
          $display("FAIL init_cmd%0d got %h required %h", i, writes[wb + i], {1'b0, init_cmds[i]});
        end
        checks++;
        if (falls[fb + i] - rises[rb + i] != EP) begin
          errors++;
          $display("FAIL init_e_width%0d got %0d required %0d", i, falls[fb + i] - rises[rb + i], EP);
        end
        if (i < 3) begin
          w = rises[rb + i + 1] - falls[fb + i] - 1;
          checks++;
          if (w != ((i == 2) ? CLRW : CMDW)) begin
            errors++;
            $display("FAIL init_wait%0d got %0d required %0d", i, w, (i == 2) ? CLRW : CMDW);
          end
        end
      end
      checks++;
      if (cyc - falls[fb + 3] != CMDW) begin
        errors++;
        $display("FAIL init_done_timing got %0d required %0d", cyc - falls[fb + 3], CMDW);
      end
    end
  endtask

  // One pattern frame (0x41+index) followed by randomized frames.
  task automatic test_frames();
    logic [8:0] exp_q [$];
    int wb, fd0, busy_low;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 32; i++) tbl[i] = (it == 0) ? 8'(8'h41 + i) : 8'($urandom_range(32, 126));
      exp_q.delete();
      exp_q.push_back({1'b0, 8'h80});
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, tbl[i]});
      exp_q.push_back({1'b0, 8'hC0});
      for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, tbl[i]});
      wb = writes.size();
      fd0 = fd_count;
      busy_low = 0;
      pulse_refresh();
      for (int k = 0; k < 2000 && fd_count == fd0; k++) begin
        if (!frame_done && !busy) busy_low++;
        @(negedge clk);
      end
      checks++;
      if (fd_count - fd0 != 1) begin
        errors++;
        $display("FAIL frame%0d_done got %0d pulses required 1", it, fd_count - fd0);
      end
      checks++;
      if (busy_low != 0) begin
        errors++;
        $display("FAIL frame%0d_busy low for %0d clks required 0", it, busy_low);
      end
      checks++;
      if (writes.size() - wb != 34) begin
        errors++;
        $display("FAIL frame%0d_count got %0d writes required 34", it, writes.size() - wb);
      end else begin
        for (int i = 0; i < 34; i++) begin
          checks++;
          if (writes[wb + i] !== exp_q[i]) begin
            errors++;
            $display("FAIL frame%0d_write%0d got %h required %h", it, i, writes[wb + i], exp_q[i]);
          end
        end
      end
      repeat (40) @(negedge clk);
      checks++;
      if (writes.size() - wb != 34 || busy !== 1'b0 || index !== 5'd0) begin
        errors++;
        $display("FAIL frame%0d_idle writes=%0d busy=%b index=%0d required 34 0 0", it, writes.size() - wb, busy, index);
      end
    end
  endtask

  // refresh in the frame_done cycle starts the next frame on the next clk.
  task automatic test_back_to_back();
    int wb, fd0;
    wb = writes.size();
    fd0 = fd_count;
    pulse_refresh();
    for (int k = 0; k < 2000 && !frame_done; k++) @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    checks++;
    if ({busy, index, lcd_rs, lcd_data} !== {1'b1, 5'd0, 1'b0, 8'h80}) begin
      errors++;
      $display("FAIL b2b_start got busy=%b idx=%0d rs=%b data=%h required 1 0 0 80", busy, index, lcd_rs, lcd_data);
    end
    for (int k = 0; k < 2000 && fd_count - fd0 < 2; k++) @(negedge clk);
    repeat (40) @(negedge clk);
    checks++;
    if (fd_count - fd0 != 2 || writes.size() - wb != 68) begin
      errors++;
      $display("FAIL b2b_frames got %0d frames %0d writes required 2 68", fd_count - fd0, writes.size() - wb);
    end
  endtask

  // refresh during power-up is held; three mid-frame requests collapse to one.
  task automatic test_pending();
    int wb, fd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    pulse_refresh();
    for (int k = 0; k < 400 && !init_done; k++) @(negedge clk);
    wb = writes.size();
    fd0 = fd_count;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL pending_after_init busy=%b required 1", busy);
    end
    for (int k = 0; k < 2000 && writes.size() - wb < 10; k++) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      pulse_refresh();
      repeat (5) @(negedge clk);
    end
    for (int k = 0; k < 3000 && fd_count - fd0 < 2; k++) @(negedge clk);
    repeat (200) @(negedge clk);
    checks++;
    if (fd_count - fd0 != 2 || writes.size() - wb != 68) begin
      errors++;
      $display("FAIL pending_frames got %0d frames %0d writes required 2 68", fd_count - fd0, writes.size() - wb);
    end
  endtask

  task automatic test_reset_mid();
    int wb;
    pulse_refresh();
    for (int k = 0; k < 2000 && !(lcd_e && lcd_rs && index == 5'd20); k++) @(negedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (lcd_e !== 1'b1 || index !== 5'd20) begin
      errors++;
      $display("FAIL mid_pre e=%b idx=%0d required 1 20", lcd_e, index);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (lcd_e !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_e got %b required 0", lcd_e);
    end
    checks++;
    if ({index, lcd_rs, lcd_data, init_done, busy, frame_done} !== 17'd0) begin
      errors++;
      $display("FAIL mid_reset_vals idx=%0d rs=%b data=%h id=%b busy=%b fd=%b required 0", index, lcd_rs, lcd_data, init_done, busy, frame_done);
    end
    repeat (2) @(negedge clk);
    wb = writes.size();
    test_init();
    repeat (100) @(negedge clk);
    checks++;
    if (writes.size() - wb != 4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_frame writes=%0d busy=%b required 4 0", writes.size() - wb, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tbl[i] = 8'h20;
    test_reset();
    test_init();
    test_frames();
    test_back_to_back();
    test_pending();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
